// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its serial-frame controller.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Counter width for a count of n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usr_core.sv
// Universal shift register: hold, shift-right (sin into MSB), shift-left (sin into LSB), parallel load.
module usr_core
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  mode_e            mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            case (mode)
                MODE_SHR:  q <= {sin, q[WIDTH-1:1]};
                MODE_SHL:  q <= {q[WIDTH-2:0], sin};
                MODE_LOAD: q <= pin;
                default:   q <= q;
            endcase
        end
    end

    assign pout = q;

endmodule

// File: rtl/usr_serdes_ctrl.sv
// Full-duplex serial frame controller: loads a word, shifts it out while shifting ser_in in,
// then offers the captured word on a valid/ready output.
module usr_serdes_ctrl
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             lsb_first,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);

    localparam int unsigned BW = cnt_width(WIDTH);
    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);

    state_e          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic            order_q, order_d;
    logic            busy_q;
    mode_e           mode;
    logic [WIDTH-1:0] reg_q;

    usr_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sin   (ser_in),
        .pin   (tx_data),
        .pout  (reg_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            clk_cnt_q <= '0;
            order_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            clk_cnt_q <= clk_cnt_d;
            order_q   <= order_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // Next-state and shift-register mode sequencing.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        clk_cnt_d = clk_cnt_q;
        order_d   = order_q;
        mode      = MODE_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    mode      = MODE_LOAD;
                    order_d   = lsb_first;
                    bit_cnt_d = '0;
                    clk_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    mode      = order_q ? MODE_SHR : MODE_SHL;
                    if (bit_cnt_q == BW'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (rx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line idles high outside a frame; during SHIFT it shows the outgoing end of the register.
    assign ser_out  = (state_q == ST_SHIFT) ? (order_q ? reg_q[0] : reg_q[WIDTH-1]) : 1'b1;
    assign tx_ready = (state_q == ST_IDLE);
    assign rx_valid = (state_q == ST_DONE);
    assign rx_data  = reg_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_usr_serdes_ctrl.sv
// Directed bench for usr_serdes_ctrl: C=2 instance for bit order, stall and reset; C=1 for back-to-back.
module tb_usr_serdes_ctrl;

    logic clk;
    logic rst_n;

    logic       a_tx_valid, a_tx_ready, a_lsb, a_ser_in, a_ser_out;
    logic       a_rx_valid, a_rx_ready, a_busy, a_loop, a_ser_drv;
    logic [3:0] a_tx_data, a_rx_data;

    logic       b_tx_valid, b_tx_ready, b_lsb, b_ser_in, b_ser_out;
    logic       b_rx_valid, b_rx_ready, b_busy;
    logic [3:0] b_tx_data, b_rx_data;

    int total = 0;
    int bad   = 0;

    assign a_ser_in = a_loop ? a_ser_out : a_ser_drv;
    assign b_ser_in = b_ser_out;

    usr_serdes_ctrl #(.WIDTH(4), .CLKS_PER_BIT(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_data(a_tx_data),
        .lsb_first(a_lsb), .ser_in(a_ser_in), .ser_out(a_ser_out),
        .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_data(a_rx_data),
        .busy(a_busy)
    );

    usr_serdes_ctrl #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
        .lsb_first(b_lsb), .ser_in(b_ser_in), .ser_out(b_ser_out),
        .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One C=2 frame on instance a; sin_k[k]/out_k[k] are ser_in/ser_out during bit k.
    task automatic a_frame(input logic [3:0] data, input logic lsb, input logic loop,
                           input logic [3:0] sin_k, input logic [3:0] out_k,
                           input logic [3:0] exp_rx);
        int n;
        n = 0;
        while (!a_tx_ready && n < 20) begin
            tick();
            n++;
        end
        chk("a_tx_ready_wait", 32'(a_tx_ready), 32'(1));
        a_loop     = loop;
        a_tx_data  = data;
        a_lsb      = lsb;
        a_tx_valid = 1'b1;
        a_rx_ready = 1'b0;
        tick();
        a_tx_valid = 1'b0;
        a_lsb      = ~lsb;
        a_tx_data  = ~data;
        chk("a_tx_ready_shift", 32'(a_tx_ready), 32'(0));
        chk("a_busy_shift", 32'(a_busy), 32'(1));
        for (int k = 0; k < 4; k++) begin
            a_ser_drv = sin_k[k];
            for (int c = 0; c < 2; c++) begin
                chk("a_ser_out", 32'(a_ser_out), 32'(out_k[k]));
                chk("a_rx_valid_early", 32'(a_rx_valid), 32'(0));
                tick();
            end
        end
        chk("a_rx_valid", 32'(a_rx_valid), 32'(1));
        chk("a_rx_data", 32'(a_rx_data), 32'(exp_rx));
        chk("a_ser_out_done", 32'(a_ser_out), 32'(1));
        a_tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_stall_rx_valid", 32'(a_rx_valid), 32'(1));
            chk("a_stall_rx_data", 32'(a_rx_data), 32'(exp_rx));
            chk("a_stall_tx_ready", 32'(a_tx_ready), 32'(0));
            chk("a_stall_busy", 32'(a_busy), 32'(1));
        end
        a_tx_valid = 1'b0;
        a_rx_ready = 1'b1;
        tick();
        a_rx_ready = 1'b0;
        chk("a_rx_valid_after", 32'(a_rx_valid), 32'(0));
        chk("a_tx_ready_after", 32'(a_tx_ready), 32'(1));
        chk("a_busy_after", 32'(a_busy), 32'(0));
        chk("a_ser_out_idle", 32'(a_ser_out), 32'(1));
    endtask

    initial begin
        logic [3:0] va;
        logic [3:0] v5;
        int low;
        int rxv;
        logic seen;

        rst_n = 1'b0;
        a_tx_valid = 1'b0; a_tx_data = '0; a_lsb = 1'b1; a_rx_ready = 1'b0;
        a_loop = 1'b0; a_ser_drv = 1'b0;
        b_tx_valid = 1'b0; b_tx_data = '0; b_lsb = 1'b1; b_rx_ready = 1'b0;
        #12;
        chk("rst_tx_ready", 32'(a_tx_ready), 32'(1));
        chk("rst_rx_valid", 32'(a_rx_valid), 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));
        chk("rst_ser_out", 32'(a_ser_out), 32'(1));
        chk("rst_rx_data", 32'(a_rx_data), 32'(0));
        chk("rst_b_ser_out", 32'(b_ser_out), 32'(1));
        rst_n = 1'b1;
        tick();

        // Loopback LSB-first, then MSB-first with ser_in low.
        a_frame(4'b1011, 1'b1, 1'b1, 4'b0000, 4'b1011, 4'b1011);
        a_frame(4'b1011, 1'b0, 1'b0, 4'b0000, 4'b1101, 4'b0000);
        // ser_in 1,0,0,1 and 1,1,0,0 per bit, both orders, tx word zero.
        a_frame(4'b0000, 1'b1, 1'b0, 4'b1001, 4'b0000, 4'b1001);
        a_frame(4'b0000, 1'b0, 1'b0, 4'b1001, 4'b0000, 4'b1001);
        a_frame(4'b0000, 1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0011);
        a_frame(4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0000, 4'b1100);
        // MSB-first 0110 out while 1,0,1,0 comes in.
        a_frame(4'b0110, 1'b0, 1'b0, 4'b0101, 4'b0110, 4'b1010);

        // Abort during bit 2.
        a_loop = 1'b1; a_tx_data = 4'b1011; a_lsb = 1'b1; a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
        repeat (4) tick();
        chk("abort_busy_before", 32'(a_busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx_ready", 32'(a_tx_ready), 32'(1));
        chk("abort_rx_valid", 32'(a_rx_valid), 32'(0));
        chk("abort_busy", 32'(a_busy), 32'(0));
        chk("abort_ser_out", 32'(a_ser_out), 32'(1));
        chk("abort_rx_data", 32'(a_rx_data), 32'(0));
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_rx_valid || a_busy) seen = 1'b1;
        end
        chk("abort_no_stale", 32'(seen), 32'(0));
        a_frame(4'b1011, 1'b1, 1'b1, 4'b0000, 4'b1011, 4'b1011);

        // C=1 back-to-back loopback frames A then 5.
        va = 4'hA;
        v5 = 4'h5;
        low = 0;
        rxv = 0;
        b_tx_data = va; b_tx_valid = 1'b1; b_rx_ready = 1'b1; b_lsb = 1'b1;
        tick();
        b_tx_data = v5;
        for (int t = 0; t < 12; t++) begin
            if (t <= 3) chk("b_ser_out_a", 32'(b_ser_out), 32'(va[t]));
            if (t >= 6 && t <= 9) chk("b_ser_out_5", 32'(b_ser_out), 32'(v5[t-6]));
            if (t <= 4 && !b_tx_ready) low++;
            if (b_rx_valid) rxv++;
            if (t == 4) begin
                chk("b_rx_valid_a", 32'(b_rx_valid), 32'(1));
                chk("b_rx_data_a", 32'(b_rx_data), 32'(4'hA));
            end
            if (t == 5) begin
                chk("b_tx_ready_gap", 32'(b_tx_ready), 32'(1));
                chk("b_tx_low_cycles", 32'(low), 32'(5));
            end
            if (t == 10) begin
                chk("b_rx_valid_5", 32'(b_rx_valid), 32'(1));
                chk("b_rx_data_5", 32'(b_rx_data), 32'(4'h5));
                b_tx_valid = 1'b0;
            end
            tick();
        end
        chk("b_rx_valid_count", 32'(rxv), 32'(2));
        chk("b_busy_end", 32'(b_busy), 32'(0));
        chk("b_tx_ready_end", 32'(b_tx_ready), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
